// File: rtl/neuron_layer_sched.sv
// Time-multiplexed scheduler for one fully-connected layer on a single shared 4-input neuron.
// Each neuron is handled in turn: fetch its weights, load the operands, capture the result, then hand it off.
module neuron_layer_sched #(
    parameter int NEURONS = 8,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       in_x,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [11:0]       cfg_xmin,
    input  logic [11:0]       cfg_xmax,
    output logic              busy,
    output logic              done,
    output logic              wmem_en,
    output logic [ADDR_W-1:0] wmem_addr,
    input  logic [47:0]       wmem_rdata,
    output logic [31:0]       n_x,
    output logic [31:0]       n_w,
    output logic [15:0]       n_bias,
    output logic [11:0]       n_xmin,
    output logic [11:0]       n_xmax,
    input  logic [7:0]        n_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_idx,
    output logic [7:0]        res_data
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, EVAL, OUT, DONE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(NEURONS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        idx;
    logic [ADDR_W-1:0] base;
    logic              last;

    assign last      = (idx == LAST_IDX);
    assign wmem_addr = base + ADDR_W'(idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        wmem_en   = 1'b0;
        res_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                wmem_en   = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = EVAL;
            EVAL: state_nxt = OUT;
            OUT: begin
                // Single result buffer: nothing new is fetched until this result is taken.
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = last ? DONE : FETCH;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= 8'd0;
            base     <= '0;
            n_x      <= 32'd0;
            n_w      <= 32'd0;
            n_bias   <= 16'd0;
            n_xmin   <= 12'd0;
            n_xmax   <= 12'd0;
            res_idx  <= 8'd0;
            res_data <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= 8'd0;
                        base   <= cfg_base;
                        n_x    <= in_x;
                        n_xmin <= cfg_xmin;
                        n_xmax <= cfg_xmax;
                    end
                end
                LOAD: begin
                    n_w    <= wmem_rdata[31:0];
                    n_bias <= wmem_rdata[47:32];
                end
                EVAL: begin
                    res_data <= n_y;
                    res_idx  <= idx;
                end
                OUT: begin
                    if (res_ready) begin
                        idx <= last ? 8'd0 : idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Randomized self-checking bench for neuron_layer_sched with a behavioural neuron and weight memory.
// The expected per-cycle timeline is derived from the per-neuron cycle budget and the ready pattern.
module tb_neuron_layer_sched;

    localparam int NEURONS = 4;
    localparam int MAXC    = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_x;
    logic [7:0]  cfg_base;
    logic [11:0] cfg_xmin;
    logic [11:0] cfg_xmax;
    logic        busy;
    logic        done;
    logic        wmem_en;
    logic [7:0]  wmem_addr;
    logic [47:0] wmem_rdata;
    logic [31:0] n_x;
    logic [31:0] n_w;
    logic [15:0] n_bias;
    logic [11:0] n_xmin;
    logic [11:0] n_xmax;
    logic [7:0]  n_y;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_idx;
    logic [7:0]  res_data;

    logic [47:0] mem [0:255];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  accData [0:NEURONS-1];
    logic [7:0]  fetchAddr [0:NEURONS-1];
    int          accCnt;
    int          fetchCnt;
    int          doneCnt;
    int          doneAt;

    always #5 clk = ~clk;

    neuron_layer_sched #(.NEURONS(NEURONS), .ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_x(in_x), .cfg_base(cfg_base),
        .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax), .busy(busy), .done(done),
        .wmem_en(wmem_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
        .n_x(n_x), .n_w(n_w), .n_bias(n_bias), .n_xmin(n_xmin), .n_xmax(n_xmax),
        .n_y(n_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_data(res_data)
    );

    function automatic logic [7:0] neuronModel(input logic [31:0] x, input logic [31:0] w,
                                               input logic [15:0] b, input logic [11:0] lo,
                                               input logic [11:0] hi);
        int acc;
        acc = int'($signed(b));
        for (int k = 0; k < 4; k++)
            acc += int'($signed(x[k*8 +: 8])) * int'($signed(w[k*8 +: 8]));
        acc = acc >>> 7;
        if (acc < int'($signed(lo))) acc = int'($signed(lo));
        if (acc > int'($signed(hi))) acc = int'($signed(hi));
        return acc[7:0];
    endfunction

    assign n_y = neuronModel(n_x, n_w, n_bias, n_xmin, n_xmax);

    always @(posedge clk) begin
        if (wmem_en) wmem_rdata <= mem[wmem_addr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // readyMode: 0 = always ready, 1 = low in cycles 4..6, 2 = random.
    task automatic applyStimulus(input logic [31:0] x, input logic [7:0] base,
                                 input logic [11:0] xmin, input logic [11:0] xmax,
                                 input int readyMode, input int startA, input int startB,
                                 input int rstCycle);
        bit         rdy [MAXC];
        int         fetchIdx [MAXC];
        int         validIdx [MAXC];
        int         t, a, doneCyc, lastCyc, i;
        logic [7:0] a8;
        logic       inReset;

        for (int c = 0; c < MAXC; c++) begin
            case (readyMode)
                0:       rdy[c] = 1'b1;
                1:       rdy[c] = !(c >= 4 && c <= 6);
                default: rdy[c] = (c > 150) || ($urandom_range(0, 9) < 6);
            endcase
            fetchIdx[c] = -1;
            validIdx[c] = -1;
        end
        t = 0;
        for (int n = 0; n < NEURONS; n++) begin
            fetchIdx[t + 1] = n;
            a = t + 4;
            while (a < MAXC - 1 && !rdy[a]) a++;
            for (int c = t + 4; c <= a; c++) validIdx[c] = n;
            t = a;
        end
        doneCyc = t + 1;
        lastCyc = (rstCycle >= 0) ? rstCycle + 1 : doneCyc + 1;

        accCnt = 0; fetchCnt = 0; doneCnt = 0; doneAt = -1;
        in_x = x; cfg_base = base; cfg_xmin = xmin; cfg_xmax = xmax; start = 1'b1;
        @(posedge clk); #1;
        in_x = $urandom; cfg_base = 8'($urandom); cfg_xmin = 12'($urandom); cfg_xmax = 12'($urandom);

        for (int c = 1; c <= lastCyc; c++) begin
            start = (c == startA) || (c == startB);
            if (start) begin
                in_x = $urandom; cfg_base = 8'($urandom);
            end
            rst = (c == rstCycle);
            res_ready = rdy[c];
            inReset = (rstCycle >= 0) && (c > rstCycle);

            checkOutput("busy", 64'(busy), 64'(!inReset && c <= doneCyc));
            checkOutput("done", 64'(done), 64'(!inReset && c == doneCyc));
            checkOutput("wmem_en", 64'(wmem_en), 64'(!inReset && fetchIdx[c] >= 0));
            checkOutput("res_valid", 64'(res_valid), 64'(!inReset && validIdx[c] >= 0));
            if (!inReset && fetchIdx[c] >= 0) begin
                a8 = base + 8'(fetchIdx[c]);
                checkOutput("wmem_addr", 64'(wmem_addr), 64'(a8));
            end
            if (!inReset && validIdx[c] >= 0) begin
                i = validIdx[c];
                a8 = base + 8'(i);
                checkOutput("res_idx", 64'(res_idx), 64'(i));
                checkOutput("res_data", 64'(res_data),
                            64'(neuronModel(x, mem[a8][31:0], mem[a8][47:32], xmin, xmax)));
                checkOutput("n_w", 64'(n_w), 64'(mem[a8][31:0]));
                checkOutput("n_bias", 64'(n_bias), 64'(mem[a8][47:32]));
            end
            if (!inReset && c <= doneCyc) begin
                checkOutput("n_x", 64'(n_x), 64'(x));
                checkOutput("n_xmin", 64'(n_xmin), 64'(xmin));
                checkOutput("n_xmax", 64'(n_xmax), 64'(xmax));
            end
            if (inReset) begin
                checkOutput("rst_res_idx", 64'(res_idx), 64'd0);
                checkOutput("rst_res_data", 64'(res_data), 64'd0);
                checkOutput("rst_n_x", 64'(n_x), 64'd0);
                checkOutput("rst_n_w", 64'(n_w), 64'd0);
                checkOutput("rst_n_bias", 64'(n_bias), 64'd0);
                checkOutput("rst_n_xmin", 64'(n_xmin), 64'd0);
                checkOutput("rst_n_xmax", 64'(n_xmax), 64'd0);
            end

            if (res_valid && res_ready) begin
                if (accCnt < NEURONS) accData[accCnt] = res_data;
                accCnt++;
            end
            if (wmem_en) begin
                if (fetchCnt < NEURONS) fetchAddr[fetchCnt] = wmem_addr;
                fetchCnt++;
            end
            if (done) begin
                doneCnt++;
                doneAt = c;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst = 1'b0;
        res_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; res_ready = 1'b0;
        in_x = 32'd0; cfg_base = 8'd0; cfg_xmin = 12'd0; cfg_xmax = 12'd0;
        for (int k = 0; k < 256; k++) mem[k] = {16'($urandom), 32'($urandom)};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_wmem_en", 64'(wmem_en), 64'd0);
        checkOutput("reset_res_valid", 64'(res_valid), 64'd0);
        checkOutput("reset_res_idx", 64'(res_idx), 64'd0);
        checkOutput("reset_res_data", 64'(res_data), 64'd0);
        checkOutput("reset_n_x", 64'(n_x), 64'd0);
        checkOutput("reset_n_w", 64'(n_w), 64'd0);
        checkOutput("reset_n_bias", 64'(n_bias), 64'd0);

        // Basic layer: neuron 0 lands at 50, neuron 1 saturates at the upper bound.
        mem[8'h10] = {16'd0, {4{8'd64}}};
        mem[8'h11] = {16'd12800, {4{8'd64}}};
        applyStimulus({8'd40, 8'd30, 8'd20, 8'd10}, 8'h10, 12'(-100), 12'd100, 0, -1, -1, -1);
        checkOutput("basic_y0", 64'(accData[0]), 64'd50);
        checkOutput("basic_y1", 64'(accData[1]), 64'd100);
        checkOutput("basic_count", 64'(accCnt), 64'(NEURONS));
        checkOutput("basic_done_cycle", 64'(doneAt), 64'(4 * NEURONS + 1));

        applyStimulus({8'd40, 8'd30, 8'd20, 8'd10}, 8'h10, 12'(-100), 12'd100, 1, -1, -1, -1);
        checkOutput("bp_y0", 64'(accData[0]), 64'd50);
        checkOutput("bp_done_cycle", 64'(doneAt), 64'(4 * NEURONS + 4));

        applyStimulus($urandom, 8'hFE, 12'(-128), 12'd127, 0, -1, -1, -1);
        checkOutput("wrap_addr0", 64'(fetchAddr[0]), 64'h0FE);
        checkOutput("wrap_addr1", 64'(fetchAddr[1]), 64'h0FF);
        checkOutput("wrap_addr2", 64'(fetchAddr[2]), 64'h000);
        checkOutput("wrap_addr3", 64'(fetchAddr[3]), 64'h001);

        applyStimulus($urandom, 8'h20, 12'(-50), 12'd60, 0, 2, 6, -1);
        checkOutput("ignored_start_done_count", 64'(doneCnt), 64'd1);
        checkOutput("ignored_start_fetches", 64'(fetchCnt), 64'(NEURONS));

        applyStimulus($urandom, 8'h40, 12'(-128), 12'd127, 0, -1, -1, 5);
        checkOutput("midrst_no_done", 64'(doneCnt), 64'd0);
        applyStimulus($urandom, 8'h60, 12'(-90), 12'd90, 0, -1, -1, -1);
        checkOutput("midrst_restart_addr0", 64'(fetchAddr[0]), 64'h060);
        checkOutput("midrst_restart_done_count", 64'(doneCnt), 64'd1);

        for (int r = 0; r < 8; r++) begin
            applyStimulus($urandom, 8'($urandom), 12'(-int'($urandom_range(0, 128))),
                          12'($urandom_range(0, 127)), 2, -1, -1, -1);
            checkOutput("rand_accepted", 64'(accCnt), 64'(NEURONS));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
